// File: rtl/fp_divsqrt_reservation_ctrl_pkg.sv
// rtl/fp_divsqrt_reservation_ctrl_pkg.sv - shared FP op-format package: unit state enum and active-list age compare
package fp_divsqrt_reservation_ctrl_pkg;

    typedef enum logic [1:0] {
        RS_FREE     = 2'd0,
        RS_RESERVED = 2'd1,
        RS_BUSY     = 2'd2,
        RS_DONE     = 2'd3
    } rs_state_e;

    // Ages are distances from the active-list head, so the compare survives index wrap-around.
    function automatic logic age_ge(
        input logic [31:0] owner,
        input logic [31:0] flush_idx,
        input logic [31:0] head,
        input int unsigned idx_w
    );
        logic [31:0] mask;
        logic [31:0] owner_age;
        logic [31:0] flush_age;
        mask      = (idx_w >= 32) ? '1 : ((32'd1 << idx_w) - 32'd1);
        owner_age = (owner - head) & mask;
        flush_age = (flush_idx - head) & mask;
        return owner_age >= flush_age;
    endfunction

endpackage

// File: rtl/fp_divsqrt_watchdog.sv
// rtl/fp_divsqrt_watchdog.sv - consecutive-BUSY-cycle watchdog, built only with RSD_FP_DIVSQRT_WATCHDOG_EN
module fp_divsqrt_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic expire,
    output logic timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] busy_cnt;

    // busy_cnt holds the number of BUSY cycles already completed, so it fires on the last allowed one.
    assign expire = busy && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!busy || expire) begin
                busy_cnt <= '0;
            end else begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_divsqrt_reservation_ctrl.sv
// rtl/fp_divsqrt_reservation_ctrl.sv - FP div/sqrt unit reservation FSM; optional watchdog via RSD_FP_DIVSQRT_WATCHDOG_EN
module fp_divsqrt_reservation_ctrl
    import fp_divsqrt_reservation_ctrl_pkg::*;
#(
    parameter int unsigned AL_IDX_W       = 6,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acquire,
    input  logic [AL_IDX_W-1:0] acquire_ptr,
    input  logic                req,
    input  logic                unit_finished,
    input  logic                release_op,
    input  logic                flush,
    input  logic [AL_IDX_W-1:0] flush_ptr,
    input  logic [AL_IDX_W-1:0] al_head,
    output logic                free,
    output logic                reserved,
    output logic                busy,
    output logic                finished,
    output logic                start,
    output logic                kill,
    output logic [AL_IDX_W-1:0] owner_ptr,
    output logic                timeout_err
);

    rs_state_e state;
    rs_state_e state_next;
    logic      owner_load;
    logic      flush_hit;
    logic      wd_expire;

    assign flush_hit = flush && (state != RS_FREE) &&
                       age_ge(32'(owner_ptr), 32'(flush_ptr), 32'(al_head), AL_IDX_W);

`ifdef RSD_FP_DIVSQRT_WATCHDOG_EN
    fp_divsqrt_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .busy        (state == RS_BUSY),
        .expire      (wd_expire),
        .timeout_err (timeout_err)
    );
`else
    // No watchdog: a negative limit is the only way to fire, and that never happens.
    assign wd_expire   = (TIMEOUT_CYCLES < 0);
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RS_FREE;
            owner_ptr <= '0;
        end else begin
            state <= state_next;
            if (owner_load) begin
                owner_ptr <= acquire_ptr;
            end
        end
    end

    // Flush outranks every other event; the watchdog outranks a same-cycle unit_finished.
    always_comb begin
        state_next = state;
        owner_load = 1'b0;
        start      = 1'b0;
        kill       = 1'b0;
        unique case (state)
            RS_FREE: begin
                if (acquire) begin
                    state_next = RS_RESERVED;
                    owner_load = 1'b1;
                end
            end
            RS_RESERVED: begin
                if (flush_hit) begin
                    state_next = RS_FREE;
                end else if (req) begin
                    state_next = RS_BUSY;
                    start      = rst;
                end
            end
            RS_BUSY: begin
                if (flush_hit || wd_expire) begin
                    state_next = RS_FREE;
                    kill       = rst;
                end else if (unit_finished) begin
                    state_next = RS_DONE;
                end
            end
            RS_DONE: begin
                if (flush_hit || release_op) begin
                    state_next = RS_FREE;
                end
            end
            default: state_next = RS_FREE;
        endcase
    end

    assign free     = (state == RS_FREE);
    assign reserved = (state == RS_RESERVED);
    assign busy     = (state == RS_BUSY);
    assign finished = (state == RS_DONE);

endmodule

// File: tb/tb_fp_divsqrt_reservation_ctrl.sv
// tb/tb_fp_divsqrt_reservation_ctrl.sv - directed bench with behavioural model for fp_divsqrt_reservation_ctrl
module tb_fp_divsqrt_reservation_ctrl;

    localparam int AW   = 6;
    localparam int TMO  = 4;
    localparam int SPAN = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          acquire = 1'b0;
    logic [AW-1:0] acquire_ptr = '0;
    logic          req = 1'b0;
    logic          unit_finished = 1'b0;
    logic          release_op = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] flush_ptr = '0;
    logic [AW-1:0] al_head = '0;
    logic          free, reserved, busy, finished, start, kill, timeout_err;
    logic [AW-1:0] owner_ptr;

    int vectors = 0;
    int miscompares = 0;
    int n_start = 0;
    int n_kill = 0;
    int mark;

    fp_divsqrt_reservation_ctrl #(
        .AL_IDX_W       (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .acquire       (acquire),
        .acquire_ptr   (acquire_ptr),
        .req           (req),
        .unit_finished (unit_finished),
        .release_op    (release_op),
        .flush         (flush),
        .flush_ptr     (flush_ptr),
        .al_head       (al_head),
        .free          (free),
        .reserved      (reserved),
        .busy          (busy),
        .finished      (finished),
        .start         (start),
        .kill          (kill),
        .owner_ptr     (owner_ptr),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Model: phase 0 free, 1 reserved, 2 busy, 3 done.
    int m_phase = 0;
    int m_owner = 0;
    int m_busy_cycles = 0;
    bit m_terr = 1'b0;

    function automatic bit m_hit();
        int owner_age;
        int flush_age;
        if (!flush || m_phase == 0) return 1'b0;
        owner_age = (m_owner - int'(al_head) + SPAN) % SPAN;
        flush_age = (int'(flush_ptr) - int'(al_head) + SPAN) % SPAN;
        return owner_age >= flush_age;
    endfunction

    function automatic bit m_timeout();
`ifdef RSD_FP_DIVSQRT_WATCHDOG_EN
        return (m_phase == 2) && (m_busy_cycles + 1 == TMO);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_start();
        return rst && m_phase == 1 && req && !m_hit();
    endfunction

    function automatic bit exp_kill();
        return rst && m_phase == 2 && (m_hit() || m_timeout());
    endfunction

    always @(posedge clk or negedge rst) begin
        bit hit;
        bit tmo;
        int nxt;
        if (!rst) begin
            m_phase       <= 0;
            m_owner       <= 0;
            m_busy_cycles <= 0;
            m_terr        <= 1'b0;
        end else begin
            hit = m_hit();
            tmo = m_timeout();
            nxt = m_phase;
            if (m_phase == 0) begin
                if (acquire) begin
                    nxt = 1;
                    m_owner <= int'(acquire_ptr);
                end
            end else if (hit) nxt = 0;
            else if (m_phase == 1 && req) nxt = 2;
            else if (m_phase == 2 && tmo) nxt = 0;
            else if (m_phase == 2 && unit_finished) nxt = 3;
            else if (m_phase == 3 && release_op) nxt = 0;
            if (tmo) m_terr <= 1'b1;
            m_busy_cycles <= (m_phase == 2 && nxt == 2) ? m_busy_cycles + 1 : 0;
            m_phase <= nxt;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("free", int'(free), int'(m_phase == 0));
        check("reserved", int'(reserved), int'(m_phase == 1));
        check("busy", int'(busy), int'(m_phase == 2));
        check("finished", int'(finished), int'(m_phase == 3));
        check("owner_ptr", int'(owner_ptr), m_owner);
        check("start", int'(start), int'(exp_start()));
        check("kill", int'(kill), int'(exp_kill()));
        check("timeout_err", int'(timeout_err), int'(m_terr));
        if (start) n_start++;
        if (kill) n_kill++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        repeat (2) step();
        check("rst_free", int'(free), 1);
        check("rst_owner", int'(owner_ptr), 0);
        check("rst_start", int'(start), 0);
        rst = 1'b1;
        step();

        // Full lifecycle, owner 5
        mark = n_start;
        acquire = 1'b1; acquire_ptr = 6'd5; step(); acquire = 1'b0;
        check("life_reserved", int'(reserved), 1);
        check("life_owner", int'(owner_ptr), 5);
        step();
        req = 1'b1; #1;
        check("life_start_comb", int'(start), 1);
        step(); req = 1'b0;
        check("life_busy", int'(busy), 1);
        repeat (9) step();
        unit_finished = 1'b1; step(); unit_finished = 1'b0;
        check("life_finished", int'(finished), 1);
        req = 1'b1; acquire = 1'b1; acquire_ptr = 6'd9; step(); req = 1'b0; acquire = 1'b0;
        check("done_ignores_req_acq", int'(finished), 1);
        release_op = 1'b1; step(); release_op = 1'b0;
        check("life_free", int'(free), 1);
        check("life_owner_kept", int'(owner_ptr), 5);
        check("life_one_start", n_start - mark, 1);

        // Flush in BUSY: owner 10, head 8
        acquire = 1'b1; acquire_ptr = 6'd10; step(); acquire = 1'b0;
        req = 1'b1; step(); req = 1'b0;
        al_head = 6'd8; flush = 1'b1; flush_ptr = 6'd11; #1;
        check("younger_flush_no_kill", int'(kill), 0);
        step();
        check("younger_flush_busy", int'(busy), 1);
        flush_ptr = 6'd9; mark = n_kill; #1;
        check("busy_flush_kill", int'(kill), 1);
        step(); flush = 1'b0;
        check("busy_flush_free", int'(free), 1);
        check("busy_flush_one_kill", n_kill - mark, 1);

        // Wrap-around age compare in RESERVED: owner 2, head 60
        acquire = 1'b1; acquire_ptr = 6'd2; step(); acquire = 1'b0;
        mark = n_kill;
        al_head = 6'd60; flush = 1'b1; flush_ptr = 6'd3; step();
        check("wrap_not_flushed", int'(reserved), 1);
        flush_ptr = 6'd1; step(); flush = 1'b0;
        check("wrap_flushed", int'(free), 1);
        check("reserved_flush_no_kill", n_kill - mark, 0);

        // req and flush together in RESERVED
        acquire = 1'b1; acquire_ptr = 6'd7; step(); acquire = 1'b0;
        al_head = 6'd0; flush_ptr = 6'd7; flush = 1'b1; req = 1'b1; #1;
        check("flush_blocks_start", int'(start), 0);
        step(); flush = 1'b0; req = 1'b0;
        check("flush_req_free", int'(free), 1);

        // acquire while BUSY, release+acquire same cycle
        acquire = 1'b1; acquire_ptr = 6'd3; step(); acquire = 1'b0;
        req = 1'b1; step(); req = 1'b0;
        acquire = 1'b1; acquire_ptr = 6'd9; release_op = 1'b1; step(); acquire = 1'b0; release_op = 1'b0;
        check("busy_ignores_acq_owner", int'(owner_ptr), 3);
        check("busy_ignores_acq_rel", int'(busy), 1);
        unit_finished = 1'b1; step(); unit_finished = 1'b0;
        release_op = 1'b1; acquire = 1'b1; acquire_ptr = 6'd12; step(); release_op = 1'b0; acquire = 1'b0;
        check("release_free", int'(free), 1);
        step();
        check("no_same_cycle_acq", int'(free), 1);
        acquire = 1'b1; acquire_ptr = 6'd12; step(); acquire = 1'b0;
        check("reacquire_owner", int'(owner_ptr), 12);
        release_op = 1'b1; unit_finished = 1'b1; step(); release_op = 1'b0; unit_finished = 1'b0;
        check("reserved_ignores_rel", int'(reserved), 1);
        flush_ptr = 6'd12; flush = 1'b1; step(); flush = 1'b0;
        check("edge_equal_flushed", int'(free), 1);

        // Reset while BUSY
        acquire = 1'b1; acquire_ptr = 6'd4; step(); acquire = 1'b0;
        req = 1'b1; step(); req = 1'b0;
        mark = n_kill;
        rst = 1'b0; #1;
        check("rst_busy_free", int'(free), 1);
        check("rst_busy_busy", int'(busy), 0);
        check("rst_busy_kill", int'(kill), 0);
        check("rst_busy_owner", int'(owner_ptr), 0);
        step();
        rst = 1'b1; step();
        check("rst_no_kill", n_kill - mark, 0);

`ifdef RSD_FP_DIVSQRT_WATCHDOG_EN
        acquire = 1'b1; acquire_ptr = 6'd1; step(); acquire = 1'b0;
        req = 1'b1; step(); req = 1'b0;
        repeat (2) step();
        check("wd_third_cycle_busy", int'(busy), 1);
        step();
        check("wd_kill", int'(kill), 1);
        check("wd_err_not_yet", int'(timeout_err), 0);
        step();
        check("wd_free", int'(free), 1);
        check("wd_err_sticky", int'(timeout_err), 1);
`else
        acquire = 1'b1; acquire_ptr = 6'd1; step(); acquire = 1'b0;
        req = 1'b1; step(); req = 1'b0;
        repeat (70) step();
        check("no_wd_still_busy", int'(busy), 1);
        check("no_wd_err", int'(timeout_err), 0);
        unit_finished = 1'b1; step(); unit_finished = 1'b0;
        release_op = 1'b1; step(); release_op = 1'b0;
        check("no_wd_free", int'(free), 1);
`endif
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_divsqrt_reservation_ctrl.md
FP_DIVSQRT_RESERVATION_CTRL -- requirements
Module: fp_divsqrt_reservation_ctrl

Interface
REQ-001 SHALL have parameter AL_IDX_W, default 6, width of active-list index.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit, used only when the watchdog is compiled in.
REQ-003 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports acquire  input  1  issue stage reserves the unit; and acquire_ptr  input  AL_IDX_W  active-list index of the acquiring op.
REQ-006 SHALL have port req  input  1  execution stage launches the operation.
REQ-007 SHALL have port unit_finished  input  1  divider/sqrt datapath reports result ready.
REQ-008 SHALL have port release  input  1  execution stage consumed the result.
REQ-009 SHALL have ports flush  input  1; flush_ptr  input  AL_IDX_W  oldest flushed index; al_head  input  AL_IDX_W  active-list head.
REQ-010 SHALL have outputs free, reserved, busy, finished  output  1 each  one-hot state flags.
REQ-011 SHALL have outputs start  output  1  one-cycle launch pulse to datapath; kill  output  1  one-cycle abort pulse to datapath.
REQ-012 SHALL have output owner_ptr  output  AL_IDX_W  index of current owner.
REQ-013 SHALL have output timeout_err  output  1  sticky watchdog error.

Function
REQ-014 SHALL implement states FREE, RESERVED, BUSY, DONE; exactly one of free/reserved/busy/finished high, registered.
REQ-015 SHALL move FREE->RESERVED on acquire, capturing acquire_ptr into owner_ptr; acquire outside FREE SHALL be ignored.
REQ-016 SHALL move RESERVED->BUSY on req, with start high in that same cycle (combinational from req and RESERVED); req in any other state SHALL be ignored.
REQ-017 SHALL move BUSY->DONE on unit_finished; unit_finished outside BUSY SHALL be ignored.
REQ-018 SHALL move DONE->FREE on release; release in other states SHALL be ignored.
REQ-019 SHALL treat an owner as flushed when (owner_ptr - al_head) mod 2^AL_IDX_W >= (flush_ptr - al_head) mod 2^AL_IDX_W, with wrap-around.
REQ-020 SHALL, on flush hitting the owner in RESERVED/BUSY/DONE, go to FREE next cycle; kill SHALL pulse one cycle if the state was BUSY.
REQ-021 SHALL give flush priority over req, unit_finished and release in the same cycle; no start while flushing the owner.
REQ-022 SHALL ignore flush in FREE and flush not hitting the owner.
REQ-023 SHALL allow acquire in the cycle after returning to FREE, not in the same cycle.

Reset
REQ-024 SHALL on rst low force FREE, owner_ptr 0, timeout_err 0, counter 0; start and kill 0 while rst low.
REQ-025 SHALL abandon an in-flight operation on reset without kill pulse.

Configuration
REQ-026 SHALL with RSD_FP_DIVSQRT_WATCHDOG_EN defined count BUSY cycles; at TIMEOUT_CYCLES consecutive BUSY cycles set timeout_err, pulse kill, go FREE.
REQ-027 SHALL without RSD_FP_DIVSQRT_WATCHDOG_EN omit the counter; timeout_err tied 0.

Structure
REQ-028 SHALL place the state enum and the age-compare function in the shared FP op-format package.
REQ-029 SHALL keep it single module; the watchdog is an optional sub-module fp_divsqrt_watchdog.

Verification
REQ-030 acquire ptr=5, req +2 cycles, unit_finished +10, release +1 -> free->reserved->busy(start 1 cycle)->finished->free, owner_ptr=5.
REQ-031 BUSY owner 10, al_head 8, flush_ptr 9 -> FREE next cycle, kill one pulse.
REQ-032 owner 2, al_head 60, flush_ptr 1 (AL_IDX_W 6) -> flushed (age 6 >= 5); flush_ptr 3 -> not flushed.
REQ-033 req and flush hitting owner same cycle in RESERVED -> no start, FREE next cycle; acquire while BUSY -> ignored.
REQ-034 rst low while BUSY -> all flags except free 0 immediately, no kill.
REQ-035 watchdog on, TIMEOUT_CYCLES=4, no unit_finished -> timeout_err 1 after 4 BUSY cycles, kill pulse, FREE.
